// File: rtl/ps2_keystroke_if.sv
// PS/2 pin and keystroke output bundle for ps2_keystroke.
// The keyboard side (master) drives the raw PS/2 lines; the decoder (slave) drives the results.
interface ps2_keystroke_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [11:0] keystroke;
   logic [7:0]  scan_code;
   logic        scan_valid;
   logic        frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  keystroke, scan_code, scan_valid, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output keystroke, scan_code, scan_valid, frame_err
   );
endinterface

// File: rtl/ps2_keystroke.sv
// PS/2 scan-code-set-2 receiver and decoder producing the snake core's 12-bit keystroke vector.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking of received frames.
module ps2_keystroke #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input logic             clk,
   input logic             rst_n,
   ps2_keystroke_if.slave  bus
);

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TW  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]     clk_sync, data_sync;
   logic [FCW-1:0] clk_cnt, data_cnt;
   logic           clk_filt, data_filt, clk_filt_d;
   logic           fall;

   state_t         state;
   logic [2:0]     bit_cnt;
   logic [7:0]     shift_reg;
   logic           par_bit;
   logic [TW-1:0]  timer;
   logic [7:0]     scan_code_q;
   logic           scan_valid_q, frame_err_q;
   logic           frame_ok;

   logic           ext, brk;
   logic [7:0]     held_q;
   logic [3:0]     pulse_q;
   logic           held_hit, pulse_hit;
   logic [2:0]     held_idx;
   logic [1:0]     pulse_idx;

   // Everything clears to 0 so a line that is low at reset release can never look like a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync   <= '0;
         data_sync  <= '0;
         clk_cnt    <= '0;
         data_cnt   <= '0;
         clk_filt   <= 1'b0;
         data_filt  <= 1'b0;
         clk_filt_d <= 1'b0;
      end else begin
         clk_sync   <= {clk_sync[0], bus.ps2_clk};
         data_sync  <= {data_sync[0], bus.ps2_data};
         clk_filt_d <= clk_filt;
         if (clk_sync[1] == clk_filt) begin
            clk_cnt <= '0;
         end else if (clk_cnt == FCW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            clk_cnt  <= '0;
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end
         if (data_sync[1] == data_filt) begin
            data_cnt <= '0;
         end else if (data_cnt == FCW'(FILTER_LEN - 1)) begin
            data_filt <= data_sync[1];
            data_cnt  <= '0;
         end else begin
            data_cnt <= data_cnt + 1'b1;
         end
      end
   end

   assign fall     = clk_filt_d & ~clk_filt;
   assign frame_ok = data_filt & (~PARITY_EN | (^{par_bit, shift_reg}));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         par_bit      <= 1'b0;
         timer        <= '0;
         scan_code_q  <= '0;
         scan_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         scan_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         if (state == IDLE || fall) timer <= '0;
         else                       timer <= timer + 1'b1;
         case (state)
            IDLE: if (fall) begin
               if (!data_filt) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end else begin
                  frame_err_q <= 1'b1;
               end
            end
            DATA: if (fall) begin
               shift_reg <= {data_filt, shift_reg[7:1]};
               bit_cnt   <= bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: if (fall) begin
               par_bit <= data_filt;
               state   <= STOP;
            end
            STOP: if (fall) begin
               state <= IDLE;
               if (frame_ok) begin
                  scan_code_q  <= shift_reg;
                  scan_valid_q <= 1'b1;
               end else begin
                  frame_err_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         // A stalled keyboard clock abandons the frame so the next start bit is recognised.
         if (state != IDLE && !fall && timer == TW'(TIMEOUT - 1)) begin
            state       <= IDLE;
            frame_err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      held_hit  = 1'b0;
      held_idx  = '0;
      pulse_hit = 1'b0;
      pulse_idx = '0;
      if (ext) begin
         case (scan_code_q)
            8'h6B: begin held_hit = 1'b1; held_idx = 3'd4; end
            8'h74: begin held_hit = 1'b1; held_idx = 3'd5; end
            8'h75: begin held_hit = 1'b1; held_idx = 3'd6; end
            8'h72: begin held_hit = 1'b1; held_idx = 3'd7; end
            default: ;
         endcase
      end else begin
         case (scan_code_q)
            8'h1C: begin held_hit  = 1'b1; held_idx  = 3'd0; end
            8'h23: begin held_hit  = 1'b1; held_idx  = 3'd1; end
            8'h1D: begin held_hit  = 1'b1; held_idx  = 3'd2; end
            8'h1B: begin held_hit  = 1'b1; held_idx  = 3'd3; end
            8'h2D: begin pulse_hit = 1'b1; pulse_idx = 2'd0; end
            8'h4D: begin pulse_hit = 1'b1; pulse_idx = 2'd1; end
            8'h55: begin pulse_hit = 1'b1; pulse_idx = 2'd2; end
            8'h4E: begin pulse_hit = 1'b1; pulse_idx = 2'd3; end
            default: ;
         endcase
      end
   end

   // Prefix bytes only set flags; any other byte consumes them, known or not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext     <= 1'b0;
         brk     <= 1'b0;
         held_q  <= '0;
         pulse_q <= '0;
      end else begin
         pulse_q <= '0;
         if (frame_err_q) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (scan_valid_q) begin
            if (scan_code_q == 8'hE0) begin
               ext <= 1'b1;
            end else if (scan_code_q == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               if (held_hit)          held_q[held_idx]   <= ~brk;
               if (pulse_hit && !brk) pulse_q[pulse_idx] <= 1'b1;
               ext <= 1'b0;
               brk <= 1'b0;
            end
         end
      end
   end

   assign bus.keystroke  = {pulse_q, held_q};
   assign bus.scan_code  = scan_code_q;
   assign bus.scan_valid = scan_valid_q;
   assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keystroke.sv
// Scoreboard bench for ps2_keystroke: directed PS/2 frames push expected events, a negedge monitor pops them.
module tb_ps2_keystroke;
   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 2000;
   localparam int K_SCAN = 0, K_ERR = 1, K_KEY = 2;

   typedef struct {
      int          kind;
      logic [11:0] val;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   int   last_scan = 0;
   logic [11:0] last_key = '0;
   exp_t sb[$];

   ps2_keystroke_if bus();

   ps2_keystroke #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input int kind, input logic [11:0] val);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         $display("[TB] FAIL unexpected event kind=%0d got=%h required=none at cycle %0d", kind, val, cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind == kind && e.val == val && (e.lat < 0 || cyc - last_scan == e.lat)) passes++;
         else $display("[TB] FAIL event kind=%0d val=%h lat=%0d required kind=%0d val=%h lat=%0d",
                       kind, val, cyc - last_scan, e.kind, e.val, e.lat);
      end
   endtask

   task automatic check_now(input string name, input logic [11:0] got, input logic [11:0] req);
      checks++;
      if (got == req) passes++;
      else $display("[TB] FAIL %s got=%h required=%h", name, got, req);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         last_key = bus.keystroke;
      end else begin
         if (bus.scan_valid) begin
            check_output(K_SCAN, {4'h0, bus.scan_code});
            last_scan = cyc;
         end
         if (bus.frame_err) check_output(K_ERR, 12'h000);
         if (bus.keystroke != last_key) begin
            check_output(K_KEY, bus.keystroke);
            last_key = bus.keystroke;
         end
      end
   end

   task automatic exp_scan(input logic [7:0] code);
      sb.push_back('{K_SCAN, {4'h0, code}, -1});
   endtask

   task automatic exp_key(input logic [11:0] val, input int lat);
      sb.push_back('{K_KEY, val, lat});
   endtask

   task automatic exp_err();
      sb.push_back('{K_ERR, 12'h000, -1});
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_bit(input logic b);
      bus.ps2_data = b;
      wait_cycles(10);
      bus.ps2_clk = 1'b0;
      wait_cycles(20);
      bus.ps2_clk = 1'b1;
      wait_cycles(10);
   endtask

   task automatic apply_stimulus(input logic [7:0] code, input bit flip_par, input bit bad_stop);
      logic [10:0] bits;
      bits = {~bad_stop, (~^code) ^ flip_par, code, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(bits[i]);
      bus.ps2_data = 1'b1;
      wait_cycles(60);
   endtask

   task automatic send_partial(input logic [7:0] code, input int nbits);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(code[i]);
      bus.ps2_data = 1'b1;
   endtask

   task automatic send(input logic [7:0] code);
      apply_stimulus(code, 1'b0, 1'b0);
   endtask

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      wait_cycles(4);
      #1;
      check_now("reset keystroke", bus.keystroke, 12'h000);
      check_now("reset scan_code", {4'h0, bus.scan_code}, 12'h000);
      check_now("reset scan_valid", {11'h0, bus.scan_valid}, 12'h000);
      check_now("reset frame_err", {11'h0, bus.frame_err}, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(40);

      // W make then break.
      exp_scan(8'h1D); exp_key(12'h004, 1);
      send(8'h1D);
      exp_scan(8'hF0); exp_scan(8'h1D); exp_key(12'h000, 1);
      send(8'hF0); send(8'h1D);

      // Extended right, E0 F0 break order.
      exp_scan(8'hE0); exp_scan(8'h74); exp_key(12'h020, 1);
      send(8'hE0); send(8'h74);
      exp_scan(8'hE0); exp_scan(8'hF0); exp_scan(8'h74); exp_key(12'h000, 1);
      send(8'hE0); send(8'hF0); send(8'h74);

      // Extended down, F0 E0 break order.
      exp_scan(8'hE0); exp_scan(8'h72); exp_key(12'h080, 1);
      send(8'hE0); send(8'h72);
      exp_scan(8'hF0); exp_scan(8'hE0); exp_scan(8'h72); exp_key(12'h000, 1);
      send(8'hF0); send(8'hE0); send(8'h72);

      // Typematic speed-up pulses, break ignored.
      for (int i = 0; i < 3; i++) begin
         exp_scan(8'h55); exp_key(12'h400, 1); exp_key(12'h000, 2);
         send(8'h55);
      end
      exp_scan(8'hF0); exp_scan(8'h55);
      send(8'hF0); send(8'h55);

      // Non-extended 75 maps to nothing; break of an unheld key does nothing.
      exp_scan(8'h75);
      send(8'h75);
      exp_scan(8'hF0); exp_scan(8'h1B);
      send(8'hF0); send(8'h1B);

      // Bad stop bit drops the byte and clears the pending E0.
      exp_scan(8'hE0); exp_err();
      send(8'hE0); apply_stimulus(8'h6B, 1'b0, 1'b1);
      exp_scan(8'h74);
      send(8'h74);

      // Flipped parity on R.
`ifdef PS2_PARITY_CHECK_EN
      exp_err();
`else
      exp_scan(8'h2D); exp_key(12'h100, 1); exp_key(12'h000, 2);
`endif
      apply_stimulus(8'h2D, 1'b1, 1'b0);

      // Hold A, then a stalled frame times out without disturbing the held key.
      exp_scan(8'h1C); exp_key(12'h001, 1);
      send(8'h1C);
      exp_err();
      send_partial(8'h23, 4);
      wait_cycles(TIMEOUT + 300);
      check_now("held A after timeout", bus.keystroke, 12'h001);
      exp_scan(8'hF0); exp_scan(8'h1C); exp_key(12'h000, 1);
      send(8'hF0); send(8'h1C);

      // Reset mid-frame with W and E0 6B held.
      exp_scan(8'h1D); exp_key(12'h004, 1);
      send(8'h1D);
      exp_scan(8'hE0); exp_scan(8'h6B); exp_key(12'h014, 1);
      send(8'hE0); send(8'h6B);
      send_partial(8'h1B, 3);
      rst_n = 1'b0;
      #1;
      check_now("keystroke during reset", bus.keystroke, 12'h000);
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      wait_cycles(5);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(50);
      exp_scan(8'h4D); exp_key(12'h200, 1); exp_key(12'h000, 2);
      send(8'h4D);

      wait_cycles(200);
      checks++;
      if (sb.size() == 0) passes++;
      else $display("[TB] FAIL scoreboard drain got=%0d pending required=0", sb.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/ps2_keystroke.md
# ps2_keystroke

Turns a PS/2 keyboard (scan code set 2) into the 12-bit `keystroke` vector that drives the snake game core. It sits between the board's PS/2 pins and the core's `keystroke` input. It samples and filters the PS/2 clock and data lines, deframes 11-bit frames, and tracks E0/F0 prefixes. Key state comes out as held direction levels (bits 7:0) and single-cycle command pulses (bits 11:8).

## Interface
- `FILTER_LEN`, default 8: consecutive equal samples needed before a synchronised PS/2 line changes its filtered value.
- `TIMEOUT`, default 50000: `clk` cycles with no filtered `ps2_clk` falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).
- `clk` input 1: system clock, 50 MHz.
- `rst_n` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock from the keyboard, asynchronous.
- `ps2_data` input 1: raw PS/2 data from the keyboard, asynchronous.
- `keystroke` output 12: bit map as defined by the core.
  - [0] P1 left, [1] P1 right, [2] P1 up, [3] P1 down.
  - [7:4] P2 left, right, up, down.
  - [8] clear game, [9] pause, [10] speed up, [11] slow down.
- `scan_code` output 8: last correctly received byte, for debug.
- `scan_valid` output 1: one-cycle pulse when `scan_code` updates.
- `frame_err` output 1: one-cycle pulse when a frame is discarded.

## Operation
- Input conditioning:
  - Two-flop synchroniser on each PS/2 line.
  - Then a per-line filter: a counter up to `FILTER_LEN`, with the filtered value held until the counter saturates.
  - A falling edge is filtered `ps2_clk` going 1→0, detected by a registered copy of the filtered value.
- Receiver FSM: `IDLE`, `DATA`, `PARITY`, `STOP`.
  - `IDLE`: on a falling edge with data = 0 (start bit), go to `DATA`. A start bit of 1 pulses `frame_err` and stays in `IDLE`.
  - `DATA`: shift in 8 bits, LSB first, on 8 falling edges.
  - `PARITY`: sample the parity bit.
  - `STOP`: sample the stop bit.
  - The frame is valid when stop = 1 and the parity check passes. A valid frame loads `scan_code` and pulses `scan_valid`.
  - An invalid frame pulses `frame_err`, drops the byte and clears the E0/F0 flags.
  - Timeout: in any state other than `IDLE`, `TIMEOUT` cycles without a falling edge → `IDLE`, `frame_err` pulse, flags cleared.
- Decoder, acting on each `scan_valid` byte:
  - E0 sets `ext`; F0 sets `brk`. The two prefixes are accepted in either order.
  - Any other byte is looked up using `ext`, applied, and then `ext` and `brk` are cleared.
  - Unknown codes are ignored but still clear the flags.
- Held keys (make sets the bit, break clears it):
  - W 1D → [2], A 1C → [0], S 1B → [3], D 23 → [1].
  - E0 75 up → [6], E0 6B left → [4], E0 74 right → [5], E0 72 down → [7].
- Pulse keys (make only; break ignored; typematic repeat re-fires the pulse):
  - R 2D → [8], P 4D → [9], `=` 55 → [10], `-` 4E → [11].
- Held-key rules:
  - A break for a key not held has no effect.
  - Opposite directions may both be set; resolution belongs to the core.
  - Typematic repeat makes are idempotent.
- The non-extended code 75 (keypad 8) does not map to [6]; only E0 75 does.

## Timing
- Every output resets to 0 on `rst_n` low, immediately and asynchronously.
- Reset clears the receiver FSM, the shift register, the filters, the synchronisers, `ext`/`brk`, and all held bits.
- Let T be the cycle in which the filtered falling edge of the stop bit is detected:
  - `scan_valid`, `scan_code` or `frame_err` are registered at T+1.
  - `keystroke` updates at T+2.
- Pulse bits [11:8] are high for exactly one cycle (T+2) per make code. They are never high in consecutive cycles.
- Raw pin to filtered edge latency is 2 + `FILTER_LEN` cycles.
- The minimum PS/2 bit period (about 60 µs) far exceeds any internal latency, so no back-pressure exists.
- Reset released mid-frame: the receiver waits in `IDLE` for a valid start bit. A partial frame produces a start-bit or parity `frame_err`, or times out, but never a false key.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: odd parity is checked (the 8 data bits plus the parity bit have an odd number of ones); a mismatch gives `frame_err` and the byte is dropped.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is sampled but ignored, and only the start and stop bits are checked.

## Test plan
- Send 1D, wait, then F0 1D → `keystroke[2]` goes 1 two cycles after the stop-bit edge, then back to 0 after the break; `scan_valid` pulses 3 times.
- Send E0 74, then E0 F0 74 → `keystroke[5]` set, then cleared; `keystroke[1]` stays 0 throughout.
- Send 55 three times (typematic), then F0 55 → `keystroke[10]` shows three isolated one-cycle pulses and no pulse on the break.
- Send 2D with a flipped parity bit and `PS2_PARITY_CHECK_EN` defined → `frame_err` pulses and `keystroke[8]` stays 0. With the macro undefined → `keystroke[8]` pulses once.
- Hold A (1C), stop `ps2_clk` after 4 data bits of the next frame → `frame_err` pulses after `TIMEOUT` cycles; `keystroke[0]` stays 1; a following F0 1C clears it.
- Assert `rst_n` low mid-frame while W and E0 6B are held → `keystroke` = 0 at once; after release, a clean 4D gives exactly one `keystroke[9]` pulse.
